param_ram: RTL and testbench

PARAM_RAM -- requirements
Module: param_ram

---
 rtl/param_ram_pkg.sv | 21 ++
 rtl/param_ram.sv | 113 +++++++++++
 tb/tb_param_ram.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/param_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : param_ram_pkg
//  Description : Shared types and default widths for the self-initialising
//                parameterised RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package param_ram_pkg;

  // Default geometry: 64 words of 8 bits
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;

  // Controller state: clearing the array, or servicing requests
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage : param_ram_pkg
`default_nettype wire

// File: rtl/param_ram.sv
`default_nettype none
// ============================================================================
//  Module      : param_ram
//  Description : Single-port RAM that clears itself to INIT_VAL after reset
//                or on a clr pulse, then services one read or write per
//                cycle with a registered read port (latency 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module param_ram
  import param_ram_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid
);

  localparam int              DEPTH = 2 ** ADDR_W;
  // Last word index, sized to the one-bit-wider counter so it never wraps
  localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);

  state_t              state;
  logic [ADDR_W:0]     cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // A request only takes effect while running and not being cleared
  always_comb begin
    accept = ready && req && !clr;
  end

  // Single write port shared by the clearing sweep and user writes
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = din;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt[ADDR_W-1:0];
      mem_wdata = INIT_VAL;
    end else if (accept && wr) begin
      mem_we    = 1'b1;
    end
  end

  // Storage array: deliberately unreset, contents come from the INIT sweep.
  // While reset is held the controller sits in INIT at cnt=0, so the only
  // write that can happen is word 0 being set to INIT_VAL, which the sweep
  // does anyway; a user write can never land once reset has been seen.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Controller: init sweep, request servicing and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      cnt      <= '0;
      ready    <= 1'b0;
      dout     <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          if (clr) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= ST_RUN;
            ready <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (clr) begin
            state <= ST_INIT;
            cnt   <= '0;
            ready <= 1'b0;
            dout  <= '0;
          end else if (accept && !wr) begin
            dout     <= mem[addr];
            rd_valid <= 1'b1;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule : param_ram
`default_nettype wire

// File: tb/tb_param_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_ram
//  Description : Randomised and directed scoreboard bench for param_ram.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_ram;

  localparam int         DEPTH    = 64;
  localparam logic [7:0] INIT_VAL = 8'h00;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       req   = 1'b0;
  logic       wr    = 1'b0;
  logic       clr   = 1'b0;
  logic [5:0] addr  = '0;
  logic [7:0] din   = '0;
  logic       ready;
  logic       rd_valid;
  logic [7:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  param_ram #(
    .DATA_W  (8),
    .ADDR_W  (6),
    .INIT_VAL(INIT_VAL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wr      (wr),
    .addr    (addr),
    .din     (din),
    .clr     (clr),
    .ready   (ready),
    .dout    (dout),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_mem [DEPTH];
  int         m_init_left = DEPTH;
  bit         m_ready     = 1'b0;
  logic [7:0] m_dout      = 8'h00;
  bit         m_rdv       = 1'b0;
  logic [7:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_init_left = DEPTH;
        m_ready     = 1'b0;
        m_dout      = 8'h00;
        m_rdv       = 1'b0;
        exp_q.delete();
      end else begin
        m_rdv = 1'b0;
        if (!m_ready) begin
          if (clr) begin
            m_init_left = DEPTH;
          end else begin
            m_init_left--;
            if (m_init_left == 0) begin
              m_ready = 1'b1;
              foreach (m_mem[i]) m_mem[i] = INIT_VAL;
            end
          end
        end else if (clr) begin
          m_ready     = 1'b0;
          m_init_left = DEPTH;
          m_dout      = 8'h00;
        end else if (req) begin
          if (wr) begin
            m_mem[addr] = din;
          end else begin
            m_dout = m_mem[addr];
            m_rdv  = 1'b1;
            exp_q.push_back(m_mem[addr]);
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("ready", ready, m_ready);
      check("rd_valid", rd_valid, m_rdv);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL read_unexpected: got dout %0h with no read pending", dout);
        end else begin
          check("read_data", dout, exp_q.pop_front());
        end
      end else begin
        check("dout_hold", dout, m_dout);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = 1'b0;
    wr  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_wr(input logic [5:0] a, input logic [7:0] d);
    req = 1'b1; wr = 1'b1; addr = a; din = d;
    tick();
    idle();
  endtask

  task automatic do_rd(input logic [5:0] a, input logic [7:0] exp, input string name);
    req = 1'b1; wr = 1'b0; addr = a;
    tick();
    idle();
    check(name, dout, exp);
    check({name, "_valid"}, rd_valid, 1'b1);
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (ready !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
    if (ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: ready=%0b after %0d cycles", ready, cycles);
    end
  endtask

  initial begin
    int cyc;
    #1 reset = 1'b1;
    tick();
    tick();
    check("reset_ready", ready, 1'b0);
    check("reset_dout", dout, 8'h00);
    check("reset_rdv", rd_valid, 1'b0);
    reset = 1'b0;

    // Write during INIT must be dropped
    req = 1'b1; wr = 1'b1; addr = 6'd10; din = 8'hAA;
    tick();
    idle();
    wait_ready(cyc);
    check("init_cycles", cyc + 1, 64);

    // Writes then back-to-back reads
    req = 1'b1; wr = 1'b1; addr = 6'd24; din = 8'hC1;
    tick();
    addr = 6'd25; din = 8'h11;
    tick();
    wr = 1'b0; addr = 6'd24;
    tick();
    check("b2b_rd24", dout, 8'hC1);
    check("b2b_rd24_valid", rd_valid, 1'b1);
    addr = 6'd25;
    tick();
    check("b2b_rd25", dout, 8'h11);
    check("b2b_rd25_valid", rd_valid, 1'b1);
    idle();
    do_rd(6'd10, 8'h00, "dropped_init_wr");

    // clr from RUN
    do_wr(6'd24, 8'hC1);
    do_rd(6'd24, 8'hC1, "pre_clr_rd");
    clr = 1'b1;
    tick();
    idle();
    check("clr_ready", ready, 1'b0);
    check("clr_dout", dout, 8'h00);
    wait_ready(cyc);
    check("clr_init_cycles", cyc, 64);
    do_rd(6'd24, 8'h00, "post_clr_rd");

    // clr at cycle 30 of INIT restarts the sweep
    clr = 1'b1;
    tick();
    idle();
    repeat (29) tick();
    clr = 1'b1;
    tick();
    idle();
    wait_ready(cyc);
    check("reclr_init_cycles", cyc, 64);

    // Reset mid-RUN with a read in flight
    do_wr(6'd63, 8'hFF);
    req = 1'b1; wr = 1'b0; addr = 6'd63;
    tick();
    check("pre_rst_rd", dout, 8'hFF);
    #2 reset = 1'b1;
    #1;
    check("rst_async_ready", ready, 1'b0);
    check("rst_async_dout", dout, 8'h00);
    check("rst_async_rdv", rd_valid, 1'b0);
    idle();
    tick();
    tick();
    reset = 1'b0;
    wait_ready(cyc);
    check("rst_init_cycles", cyc, 64);
    do_rd(6'd63, 8'h00, "post_rst_rd63");
    do_rd(6'd0, 8'h00, "post_rst_rd0");

    // Randomised traffic, occasional clr and one reset pulse
    for (int i = 0; i < 3000; i++) begin
      req  = ($urandom % 4) != 0;
      wr   = $urandom % 2;
      addr = ($urandom % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      din  = 8'($urandom);
      clr  = ($urandom % 300) == 0;
      if (i == 1500) begin
        #2 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    idle();
    repeat (4) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_param_ram
`default_nettype wire
